// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: credit-based SRAM fetch feeding a DEPTH-entry {pc, inst} FIFO.
// Optional statistics counters (fetch_cnt, flush_cnt) are built when IFQ_STATS_EN is defined.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [29:0]   r_fpc;
  logic [29:0]   r_req_pc;
  logic          r_inflight;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic [CW-1:0] w_used;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic          w_head_vis;

  // Credit counts the in-flight response but deliberately ignores a same-cycle pop.
  assign w_used     = r_count + {{AW{1'b0}}, r_inflight};
  assign w_req      = !rst && !redirect_valid && (w_used < CW'(DEPTH));
  assign w_push     = !rst && !redirect_valid && r_inflight;
  assign w_head_vis = !rst && (r_count != '0);
  assign w_pop      = out_valid && out_ready;

  assign inst_sram_req  = w_req;
  assign inst_sram_addr = {r_fpc, 2'b00};
  assign out_valid      = w_head_vis && !redirect_valid;
  assign out_pc         = w_head_vis ? r_pc_mem[r_rptr]   : 32'h0;
  assign out_inst       = w_head_vis ? r_inst_mem[r_rptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc      <= RESET_PC[31:2];
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fpc      <= redirect_pc[31:2];
      r_inflight <= 1'b0;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_req_pc <= r_fpc;
        r_fpc    <= r_fpc + 30'd1;
      end
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= {r_req_pc, 2'b00};
      r_inst_mem[r_wptr] <= inst_sram_rdata;
    end
  end

`ifdef IFQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (w_pop)          fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_valid) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: random ready/redirect/reset traffic against a sequential-PC model.
module tb_if_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef IFQ_STATS_EN
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_sram_req  (inst_sram_req),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
`ifdef IFQ_STATS_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  // SRAM model: data for the address requested in the previous cycle.
  logic [31:0] sram_addr_q = 32'h0;
  always @(posedge clk) if (inst_sram_req) sram_addr_q <= inst_sram_addr;
  assign inst_sram_rdata = hsh(sram_addr_q);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected stream of accepted PCs: sequential from the most recent restart point.
  logic [31:0] exp_q[$];
  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 2048; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  int          occ = 0;
  int          infl = 0;
  int          pops_since = 0;
  int          flush_since = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_pc, prev_inst;

  always @(negedge clk) begin
    bit          exp_req, exp_valid, pop;
    logic [31:0] e;
    exp_req   = !rst && !redirect_valid && (occ + infl < DEPTH);
    exp_valid = !rst && !redirect_valid && (occ != 0);
    chk("req", inst_sram_req, exp_req);
    chk("valid", out_valid, exp_valid);
    if (rst) begin
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_inst", out_inst, 32'h0);
    end
    if (inst_sram_req) chk("addr_align", inst_sram_addr & 32'h3, 32'h0);
    if (prev_stall && out_valid) begin
      chk("hold_pc", out_pc, prev_pc);
      chk("hold_inst", out_inst, prev_inst);
    end
    pop = out_valid && out_ready;
    if (pop) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty got=%h exp=none", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_inst", out_inst, hsh(e));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_pc    = out_pc;
    prev_inst  = out_inst;
    if (rst) begin
      occ = 0; infl = 0; pops_since = 0; flush_since = 0;
    end else begin
      if (pop) pops_since++;
      if (redirect_valid) begin
        flush_since++;
        occ = 0; infl = 0;
      end else begin
        occ  = occ + infl - (pop ? 1 : 0);
        infl = exp_req ? 1 : 0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nreq;
    bit prev_redir;
    int r;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    refill(RESET_PC);
    repeat (3) @(posedge clk);
    #1;

    // First instructions appear in the third cycle after reset, back to back.
    rst = 1'b0; out_ready = 1'b1;
    #3; chk("a_valid_c0", out_valid, 1'b0); chk("a_addr_c0", inst_sram_addr, RESET_PC);
    step; #3; chk("a_valid_c1", out_valid, 1'b0);
    step; #3; chk("a_valid_c2", out_valid, 1'b1); chk("a_pc_c2", out_pc, RESET_PC);
    chk("a_inst_c2", out_inst, hsh(RESET_PC));
    step; #3; chk("a_pc_c3", out_pc, RESET_PC + 32'd4);
    step; #3; chk("a_pc_c4", out_pc, RESET_PC + 32'd8);

    // Stall: fetch stops at DEPTH, then drains in order with no gap.
    step; rst = 1'b1; out_ready = 1'b0; refill(RESET_PC);
    step; rst = 1'b0; nreq = 0;
    for (int i = 0; i < 10; i++) begin
      #3; if (inst_sram_req) nreq++;
      step;
    end
    chk("b_nreq", nreq, DEPTH);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3; chk("b_drain_valid", out_valid, 1'b1);
      chk("b_drain_pc", out_pc, RESET_PC + 32'(4 * i));
      step;
    end

    // Redirect with 3 queued + 1 in flight, unaligned target.
    rst = 1'b1; out_ready = 1'b0; refill(RESET_PC);
    step; rst = 1'b0;
    repeat (4) step;
    redirect_valid = 1'b1; redirect_pc = 32'h1c000103; out_ready = 1'b1;
    refill(32'h1c000100);
    #3; chk("c_req_t0", inst_sram_req, 1'b0); chk("c_valid_t0", out_valid, 1'b0);
    step; redirect_valid = 1'b0;
    #3; chk("c_req_t1", inst_sram_req, 1'b1); chk("c_addr_t1", inst_sram_addr, 32'h1c000100);
    chk("c_valid_t1", out_valid, 1'b0);
    step; #3; chk("c_valid_t2", out_valid, 1'b0);
    step; #3; chk("c_valid_t3", out_valid, 1'b1); chk("c_pc_t3", out_pc, 32'h1c000100);

    // Reset wins over a simultaneous redirect with a full queue.
    step; out_ready = 1'b0;
    repeat (8) step;
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1c000200; refill(RESET_PC);
    #3; chk("d_valid_rst", out_valid, 1'b0);
    step; rst = 1'b0; redirect_valid = 1'b0;
    #3; chk("d_valid", out_valid, 1'b0); chk("d_req", inst_sram_req, 1'b1);
    chk("d_addr", inst_sram_addr, RESET_PC);

    prev_redir = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step;
      rst = 1'b0; redirect_valid = 1'b0;
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        rst = 1'b1; refill(RESET_PC);
      end else if (r < 8 && !prev_redir) begin
        redirect_valid = 1'b1; redirect_pc = $urandom;
        refill({redirect_pc[31:2], 2'b00});
      end
      prev_redir = redirect_valid;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    step; rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step;
    #3;
`ifdef IFQ_STATS_EN
    chk("fetch_cnt", fetch_cnt, pops_since);
    chk("flush_cnt", {16'h0, flush_cnt}, flush_since);
    step; rst = 1'b1; refill(RESET_PC);
    step; rst = 1'b0;
    #3; chk("fetch_cnt_rst", fetch_cnt, 32'h0); chk("flush_cnt_rst", {16'h0, flush_cnt}, 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 inst_sram_req  output  1  read request to instruction SRAM this cycle.
REQ-006 inst_sram_addr  output  32  byte address of the request; bits [1:0] always 0.
REQ-007 inst_sram_rdata  input  32  read data, valid exactly one cycle after the request.
REQ-008 redirect_valid  input  1  branch-taken or flush from EX; one-cycle pulse.
REQ-009 redirect_pc  input  32  new fetch address when redirect_valid=1.
REQ-010 out_valid  output  1  an {pc, inst} pair is offered to the ID stage.
REQ-011 out_ready  input  1  ID accepts the pair (ID stall = 0).
REQ-012 out_pc  output  32  PC of the offered instruction.
REQ-013 out_inst  output  32  instruction word offered.

Function
REQ-014 Fetch PC register fpc SHALL drive inst_sram_addr; fpc SHALL advance by 4 in each cycle inst_sram_req=1.
REQ-015 inst_sram_req SHALL be 1 iff rst=0, redirect_valid=0, and (queue count + in-flight count) < DEPTH; the in-flight count is 0 or 1, set by the previous cycle's request.
REQ-016 Credit check SHALL ignore a same-cycle pop, so the queue SHALL never overflow.
REQ-017 A response (cycle after a request) SHALL be pushed as {req_pc, inst_sram_rdata}; req_pc is the address latched at request time.
REQ-018 Push and pop in the same cycle SHALL be legal at any occupancy; count is unchanged.
REQ-019 out_valid SHALL equal (count != 0) AND NOT redirect_valid; out_pc and out_inst SHALL show the head entry.
REQ-020 Pop SHALL occur iff out_valid AND out_ready; out_pc and out_inst SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 On redirect_valid=1, every queue entry and the in-flight response arriving that cycle SHALL be discarded.
REQ-022 On redirect_valid=1, no request SHALL issue, and fpc SHALL load {redirect_pc[31:2], 2'b00}.
REQ-023 Redirect latency: pulse in cycle t -> request to redirect_pc in t+1 -> push in t+2 -> out_valid=1 earliest in t+3.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH.
REQ-025 Steady-state throughput SHALL be one instruction per cycle when out_ready is held at 1.

Reset
REQ-026 On rst=1:
- fpc = RESET_PC
- count, pointers, and in-flight = 0
- inst_sram_req = 0, out_valid = 0
- out_pc = 0, out_inst = 0
REQ-027 rst SHALL take priority over redirect_valid; a response arriving in the cycle after reset SHALL be discarded.
REQ-028 Reset mid-operation SHALL drop all queued and in-flight data; the first request after rst falls SHALL address RESET_PC.

Configuration
REQ-029 Macro IFQ_STATS_EN: when defined, add output fetch_cnt (32) and output flush_cnt (16).
- fetch_cnt increments on each pop.
- flush_cnt increments on each redirect_valid=1 cycle.
- Both clear on rst and wrap on overflow.
REQ-030 Without IFQ_STATS_EN, neither port nor its counters SHALL exist; all other behaviour is identical.

Verification
REQ-031 Release reset; out_ready=1; SRAM returns the address as data -> out_pc 1c000000, 1c000004, 1c000008 on consecutive cycles from the 3rd cycle after reset; out_inst == out_pc.
REQ-032 out_ready=0 for 10 cycles -> inst_sram_req stops after DEPTH(4) fills, count = 4, no overflow; then out_ready=1 -> 1c000000..1c00000c drain in order with no gap.
REQ-033 Redirect to 1c000100 while the queue holds 3 entries and a request is in flight -> none of the old PCs reaches ID; first out_pc = 1c000100 at t+3.
REQ-034 Redirect with redirect_pc = 1c000103 -> inst_sram_addr = 1c000100.
REQ-035 rst asserted for 1 cycle with redirect_valid=1 and a full queue -> out_valid=0 next cycle; next request address = 1c000000.
REQ-036 With IFQ_STATS_EN defined: 5 pops and 2 redirects -> fetch_cnt = 5, flush_cnt = 2; rst -> both 0.
